// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with byte-lane steering and stall control
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   mem_read/write    load/store request from EX/MEM (store wins if both set)
//   addr              byte address
//   wr_data           unaligned store data
//   func3             access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   lsu_stall         hold upstream pipeline registers
//   ld_data           aligned, extended load result (valid in DONE, held otherwise)
//   misalign          illegal/misaligned access seen in IDLE; no memory op issued
//   bus_err           one-cycle pulse after a memory timeout
//   m_req..m_wdata    registered request to the data RAM, stable while BUSY
//   m_ack, m_rdata    RAM completion and read word (same cycle)
module load_store_unit #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  lsu_stall,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DM_ADDRESS-3:0] m_addr,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic             access;
  logic             illegal;
  logic             start;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      shifted;
  logic [15:0]      half_sel;
  logic [31:0]      load_val;

  assign access  = mem_read | mem_write;
  assign illegal = (func3[1:0] == 2'b11)
                 | ((func3[1:0] == 2'b01) & addr[0])
                 | ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00))
                 | (mem_write & func3[2]);
  assign start     = (state == IDLE) & access & ~illegal;
  assign misalign  = (state == IDLE) & access & illegal;
  assign lsu_stall = start | (state == BUSY);

  // Store lane steering; loads always present a full-word enable.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wr_data;
    if (mem_write) begin
      case (func3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{wr_data[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << addr[1:0];
          wdata_next = {2{wr_data[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = wr_data;
        end
      endcase
    end
  end

  // Load lane select uses the offset/size captured at issue, not the live inputs.
  assign shifted  = m_rdata >> {off_q, 3'b000};
  assign half_sel = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    load_val = m_rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = m_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_be     <= 4'd0;
      m_wdata  <= '0;
      ld_data  <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_we     <= mem_write;
            m_addr   <= addr[DM_ADDRESS-1:2];
            m_be     <= be_next;
            m_wdata  <= wdata_next;
            f3_q     <= func3;
            off_q    <= addr[1:0];
            m_req    <= 1'b1;
            wait_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (m_ack) begin
            m_req <= 1'b0;
            if (!m_we) ld_data <= load_val;
            state <= DONE;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            m_req   <= 1'b0;
            ld_data <= '0;
            bus_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // Inputs are ignored here so the still-present access cannot re-trigger.
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
